apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

Downstream APB completer that terminates one select line of the two-slave APB master: decodes `Psel`/`Penable`, inserts a programmable number of wait states, performs byte-strobed writes into a word-addressed storage array, and returns registered read data. The design instantiates it twice, once on `Psel_1` and once on `Psel_2`. The shared `Paddr`/`Pwdata`/`Pstrb`/`Pwrite` buses fan out to both instances, and the `Prdata`/`Pready` outputs of the two instances are muxed by the selected slave.

## Interface
- `ADD_WIDTH`, 8: width of `Paddr`; equals the master's `ADD_WIDTH-1`. Word address.
- `WIDTH`, 32: data width; must be a multiple of 8.
- `DEPTH`, 256: implemented words, 1..2^ADD_WIDTH.
- `WAIT_CYCLES`, 2: wait states inserted per transfer, 0..15.

Ports:
- `pclk`  in  1  APB clock; all logic on the rising edge.
- `presetn`  in  1  asynchronous, active-low reset.
- `Psel`  in  1  slave select.
- `Penable`  in  1  access phase.
- `Pwrite`  in  1  1 = write, 0 = read.
- `Pstrb`  in  WIDTH/8  write byte lanes; ignored on reads.
- `Paddr`  in  ADD_WIDTH  word address.
- `Pwdata`  in  WIDTH  write data.
- `Prdata`  out  WIDTH  read data; valid only while `Pready` is high on a read.
- `Pready`  out  1  transfer completes this cycle.
- `Pslverr`  out  1  error response; qualified by `Pready`.

## Operation
- FSM has three states: `IDLE`, `WAIT`, `READY`. Outputs are Moore: `Pready` = (state==`READY`).
- `IDLE`: if `Psel & !Penable` (setup phase), load `wait_cnt` = `WAIT_CYCLES`.
  - If `WAIT_CYCLES==0`, next state is `READY`; otherwise `WAIT`.
  - Any other input leaves the FSM in `IDLE`.
- `WAIT`: if `!Psel`, go to `IDLE` (abort; no write). Otherwise, if `wait_cnt==1`, go to `READY`; else decrement `wait_cnt`.
- `READY`: `Pready=1`. At the closing edge, if `Psel & Penable & Pwrite & !err`, write lanes `i` with `Pstrb[i]=1` (`mem[Paddr][8i+7:8i] <= Pwdata[8i+7:8i]`). Always return to `IDLE`.
- Back-to-back transfers: the master's next setup cycle lands in `IDLE` and is accepted, so no bubble is added.
- Read data path:
  - `Prdata` is a register loaded with `mem[Paddr]` on the edge entering `READY` when `!Pwrite & !err`.
  - It is loaded with 0 when `err`.
  - It is cleared to 0 on the edge leaving `READY`.
- Error:
  - `err` = (`Paddr >= DEPTH`), sampled with the setup-phase address.
  - `Pslverr` is registered alongside `Prdata`: high only in `READY` when `err`.
  - On error, the write is suppressed and read data is 0.
- `Pstrb == 0` on a write: legal. Completes normally with no storage change and `Pslverr=0`.
- Storage has no reset; contents are undefined until written.
- Address and data buses are sampled in `READY` for writes and at `READY` entry for reads. The master holds them stable for the whole transfer.

## Timing
- Reset values: state=`IDLE`, `wait_cnt`=0, `Pready`=0, `Pslverr`=0, `Prdata`=0.
- Reset mid-transfer forces these values immediately (asynchronous), and no write occurs.
- Cycle numbering: setup = T0; first access cycle = T1. `Pready` is high in T(1+`WAIT_CYCLES`), for exactly one cycle.
- Write takes effect at the rising edge ending the `Pready` cycle. A read issued in the very next transfer returns the new value.
- Transfer length, setup to completion inclusive, is `WAIT_CYCLES`+2 cycles.
- `Psel` deasserted during `WAIT` or `READY` gives `IDLE` on the next edge. `Pready`/`Pslverr`/`Prdata` return to 0 and no write occurs.

## Structure
- Package `apb_pkg` holds:
  - the FSM state encoding localparams (`IDLE`=2'b00, `WAIT`=2'b01, `READY`=2'b10);
  - the default `WIDTH`/`ADD_WIDTH` constants shared with the master.
- Sub-module `apb_strb_mem`: `DEPTH`×`WIDTH` array, one write port with per-byte enables, one combinational read port. Keeps the strobe loop out of the FSM.
- The FSM, wait counter, and output registers live in the top module.

## Test plan
- Write `Paddr`=8'h10, `Pwdata`=32'hDEADBEEF, `Pstrb`=4'hF, `WAIT_CYCLES`=2, then read 8'h10 → `Pready` in T3 of each transfer; read `Prdata`=32'hDEADBEEF, `Pslverr`=0.
- Byte strobes: after the above, write 32'h11223344 with `Pstrb`=4'b0101, then read → 32'hDE22BE44. A write with `Pstrb`=0 leaves the value unchanged.
- `WAIT_CYCLES`=0, back-to-back write/read/write with no idle cycles → `Pready` high in every access cycle; each transfer is 2 cycles; data correct.
- `DEPTH`=16: write then read to `Paddr`=8'h20 → `Pslverr`=1 with `Pready`; `Prdata`=0; word 0 is unchanged.
- Drop `Psel` in T1 of a write (`WAIT_CYCLES`=3) → `Pready` never asserts; the FSM is in `IDLE` next cycle; a later read shows the old data.
- Assert `presetn`=0 mid-`WAIT` → `Pready`/`Pslverr`/`Prdata` go to 0 immediately with no write. After release, a new transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | apb_pkg : state encoding and default bus widths shared by APB blocks     |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
package apb_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] WAIT  = 2'b01;
    localparam logic [1:0] READY = 2'b10;

    localparam int c_APB_WIDTH     = 32;
    localparam int c_APB_ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_WAIT  = WAIT,
        ST_READY = READY
    } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_strb_mem.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | apb_strb_mem : DEPTH x WIDTH storage, byte-enabled write, async read     |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module apb_strb_mem
    import apb_pkg::*;
#(
    parameter int ADD_WIDTH = c_APB_ADD_WIDTH,
    parameter int WIDTH     = c_APB_WIDTH,
    parameter int DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [WIDTH/8-1:0]   i_strb,
    input  logic [ADD_WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0]     i_wdata,
    output logic [WIDTH-1:0]     o_rdata
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LANES = WIDTH / 8;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_IDX_W-1:0] w_idx;

    // Callers only enable writes for in-range addresses, so the low bits suffice.
    assign w_idx   = i_addr[c_IDX_W-1:0];
    assign o_rdata = r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (i_strb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | apb_slave_regfile : APB completer with programmable wait states and a    |
// | byte-strobed register file. Revision: 1.0                                |
// +-------------------------------------------------------------------------+
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int ADD_WIDTH   = c_APB_ADD_WIDTH,
    parameter int WIDTH       = c_APB_WIDTH,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 Psel,
    input  logic                 Penable,
    input  logic                 Pwrite,
    input  logic [WIDTH/8-1:0]   Pstrb,
    input  logic [ADD_WIDTH-1:0] Paddr,
    input  logic [WIDTH-1:0]     Pwdata,
    output logic [WIDTH-1:0]     Prdata,
    output logic                 Pready,
    output logic                 Pslverr
);

    localparam logic [3:0]         c_WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [ADD_WIDTH:0] c_DEPTH     = (ADD_WIDTH + 1)'(DEPTH);

    apb_state_e       r_state_q,    w_state_d;
    logic [3:0]       r_wait_cnt_q, w_wait_cnt_d;
    logic             r_err_q,      w_err_d;
    logic [WIDTH-1:0] r_prdata_q,   w_prdata_d;
    logic             r_pslverr_q,  w_pslverr_d;

    logic             w_addr_err;
    logic             w_err;
    logic             w_enter_ready;
    logic             w_mem_we;
    logic [WIDTH-1:0] w_mem_rdata;

    assign w_addr_err = ({1'b0, Paddr} >= c_DEPTH);
    // With zero wait states READY is entered straight from the setup cycle,
    // before the setup-phase error flag has been registered.
    assign w_err      = (r_state_q == ST_IDLE) ? w_addr_err : r_err_q;

    always_comb begin
        w_state_d    = r_state_q;
        w_wait_cnt_d = r_wait_cnt_q;
        w_err_d      = r_err_q;
        case (r_state_q)
            ST_IDLE: begin
                if (Psel && !Penable) begin
                    w_wait_cnt_d = c_WAIT_LOAD;
                    w_err_d      = w_addr_err;
                    if (WAIT_CYCLES == 0) begin
                        w_state_d = ST_READY;
                    end else begin
                        w_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!Psel) begin
                    w_state_d = ST_IDLE;
                end else if (r_wait_cnt_q == 4'd1) begin
                    w_state_d = ST_READY;
                end else begin
                    w_wait_cnt_d = r_wait_cnt_q - 4'd1;
                end
            end
            ST_READY: w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase

        w_enter_ready = (w_state_d == ST_READY) && (r_state_q != ST_READY);
        w_prdata_d    = '0;
        w_pslverr_d   = 1'b0;
        if (w_enter_ready) begin
            w_pslverr_d = w_err;
            if (!w_err && !Pwrite) begin
                w_prdata_d = w_mem_rdata;
            end
        end
    end

    assign w_mem_we = (r_state_q == ST_READY) && Psel && Penable && Pwrite && !r_err_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state_q    <= ST_IDLE;
            r_wait_cnt_q <= 4'd0;
            r_err_q      <= 1'b0;
            r_prdata_q   <= '0;
            r_pslverr_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_wait_cnt_q <= w_wait_cnt_d;
            r_err_q      <= w_err_d;
            r_prdata_q   <= w_prdata_d;
            r_pslverr_q  <= w_pslverr_d;
        end
    end

    apb_strb_mem #(
        .ADD_WIDTH (ADD_WIDTH),
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk     (pclk),
        .i_we    (w_mem_we),
        .i_strb  (Pstrb),
        .i_addr  (Paddr),
        .i_wdata (Pwdata),
        .o_rdata (w_mem_rdata)
    );

    assign Pready  = (r_state_q == ST_READY);
    assign Prdata  = r_prdata_q;
    assign Pslverr = r_pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_apb_slave_regfile : three completers (2/0/3 wait states) on a shared  |
// | APB bus, checked against a byte-level storage model. Revision: 1.0       |
// +-------------------------------------------------------------------------+
module tb_apb_slave_regfile;

    localparam int N  = 3;
    localparam int MW = 32;
    localparam int WC [N] = '{2, 0, 3};
    localparam int DP [N] = '{256, 16, 256};

    logic        pclk = 1'b0;
    logic        presetn;
    logic [N-1:0] psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata [N];
    logic [N-1:0] pready;
    logic [N-1:0] pslverr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] mb [N][MW][4];

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        apb_slave_regfile #(
            .ADD_WIDTH   (8),
            .WIDTH       (32),
            .DEPTH       (DP[g]),
            .WAIT_CYCLES (WC[g])
        ) u_dut (
            .pclk    (pclk),
            .presetn (presetn),
            .Psel    (psel[g]),
            .Penable (penable),
            .Pwrite  (pwrite),
            .Pstrb   (pstrb),
            .Paddr   (paddr),
            .Pwdata  (pwdata),
            .Prdata  (prdata[g]),
            .Pready  (pready[g]),
            .Pslverr (pslverr[g])
        );
    end

    function automatic logic [31:0] model_rd(input int k, input int a);
        logic [31:0] v;
        v = '0;
        if (a < DP[k]) begin
            for (int b = 0; b < 4; b++) v[8*b +: 8] = mb[k][a][b];
        end
        return v;
    endfunction

    task automatic model_wr(input int k, input int a, input logic [31:0] d, input logic [3:0] s);
        if (a < DP[k]) begin
            for (int b = 0; b < 4; b++) if (s[b]) mb[k][a][b] = d[8*b +: 8];
        end
    endtask

    // One APB transfer; returns in the Pready cycle with the bus still held.
    task automatic xfer(input int k, input bit wr, input int a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic err,
                        output int lat, output int t0);
        @(posedge pclk); #1;
        t0 = cyc;
        psel = '0; psel[k] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = 8'(a); pwdata = d; pstrb = s;
        lat = -1; rd = 'x; err = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(posedge pclk); #1;
            penable = 1'b1;
            if (pready[k]) begin
                lat = c; rd = prdata[k]; err = pslverr[k];
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
            psel = '0; penable = 1'b0;
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
        pstrb = '0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge pclk);
        #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 || prdata[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_out[%0d]: pready=%b pslverr=%b prdata=%h, expected 0 0 00000000",
                         k, pready[k], pslverr[k], prdata[k]);
            end
        end
        presetn = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic err; int lat, t0;
        xfer(0, 1'b1, 'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, t0);
        model_wr(0, 'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if (lat !== 3 || err !== 1'b0) begin
            failures++;
            $display("FAIL wr_basic: latency=%0d slverr=%b, expected 3 0", lat, err);
        end
        xfer(0, 1'b0, 'h10, 32'h0, 4'h0, rd, err, lat, t0);
        checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_basic: latency=%0d slverr=%b prdata=%h, expected 3 0 deadbeef", lat, err, rd);
        end
        idle(1);
        checks++;
        if (pready[0] !== 1'b0 || prdata[0] !== 32'h0) begin
            failures++;
            $display("FAIL rd_clear: pready=%b prdata=%h, expected 0 00000000", pready[0], prdata[0]);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic err; int lat, t0;
        xfer(0, 1'b1, 'h10, 32'h11223344, 4'b0101, rd, err, lat, t0);
        model_wr(0, 'h10, 32'h11223344, 4'b0101);
        xfer(0, 1'b0, 'h10, 32'h0, 4'h0, rd, err, lat, t0);
        checks++;
        if (rd !== 32'hDE22BE44 || err !== 1'b0) begin
            failures++;
            $display("FAIL strb_0101: prdata=%h slverr=%b, expected de22be44 0", rd, err);
        end
        xfer(0, 1'b1, 'h10, 32'hFFFFFFFF, 4'h0, rd, err, lat, t0);
        checks++;
        if (lat !== 3 || err !== 1'b0) begin
            failures++;
            $display("FAIL strb_zero_wr: latency=%0d slverr=%b, expected 3 0", lat, err);
        end
        xfer(0, 1'b0, 'h10, 32'h0, 4'h0, rd, err, lat, t0);
        checks++;
        if (rd !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL strb_zero_rd: prdata=%h, expected de22be44", rd);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rds [4]; logic errs [4]; int lats [4]; int t0s [4];
        xfer(1, 1'b1, 3, 32'hA5A50001, 4'hF, rds[0], errs[0], lats[0], t0s[0]);
        xfer(1, 1'b0, 3, 32'h0,        4'h0, rds[1], errs[1], lats[1], t0s[1]);
        xfer(1, 1'b1, 3, 32'h0BADCAFE, 4'h3, rds[2], errs[2], lats[2], t0s[2]);
        xfer(1, 1'b0, 3, 32'h0,        4'h0, rds[3], errs[3], lats[3], t0s[3]);
        idle(1);
        model_wr(1, 3, 32'hA5A50001, 4'hF);
        model_wr(1, 3, 32'h0BADCAFE, 4'h3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lats[i] !== 1 || (i > 0 && t0s[i] - t0s[i-1] !== 2)) begin
                failures++;
                $display("FAIL b2b_timing[%0d]: latency=%0d spacing=%0d, expected 1 2",
                         i, lats[i], (i > 0) ? t0s[i] - t0s[i-1] : 2);
            end
        end
        checks++;
        if (rds[1] !== 32'hA5A50001 || rds[3] !== 32'hA5A5CAFE) begin
            failures++;
            $display("FAIL b2b_data: prdata=%h/%h, expected a5a50001/a5a5cafe", rds[1], rds[3]);
        end
    endtask

    task automatic test_error();
        logic [31:0] rd; logic err; int lat, t0;
        xfer(1, 1'b1, 0, 32'h13579BDF, 4'hF, rd, err, lat, t0);
        model_wr(1, 0, 32'h13579BDF, 4'hF);
        xfer(1, 1'b1, 'h20, 32'hFFFFFFFF, 4'hF, rd, err, lat, t0);
        checks++;
        if (lat !== 1 || err !== 1'b1) begin
            failures++;
            $display("FAIL err_wr: latency=%0d slverr=%b, expected 1 1", lat, err);
        end
        xfer(1, 1'b0, 'h20, 32'h0, 4'h0, rd, err, lat, t0);
        checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL err_rd: latency=%0d slverr=%b prdata=%h, expected 1 1 00000000", lat, err, rd);
        end
        xfer(1, 1'b0, 0, 32'h0, 4'h0, rd, err, lat, t0);
        checks++;
        if (err !== 1'b0 || rd !== 32'h13579BDF) begin
            failures++;
            $display("FAIL err_word0: slverr=%b prdata=%h, expected 0 13579bdf", err, rd);
        end
        idle(1);
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int lat, t0; bit seen;
        xfer(2, 1'b1, 5, 32'h5555AAAA, 4'hF, rd, err, lat, t0);
        model_wr(2, 5, 32'h5555AAAA, 4'hF);
        idle(1);
        @(posedge pclk); #1;
        psel = '0; psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h05; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge pclk); #1;
        psel = '0; penable = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (pready[2] !== 1'b0) seen = 1'b1;
            @(posedge pclk); #1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_pready: pready seen=1, expected 0");
        end
        xfer(2, 1'b0, 5, 32'h0, 4'h0, rd, err, lat, t0);
        checks++;
        if (lat !== 4 || rd !== 32'h5555AAAA) begin
            failures++;
            $display("FAIL abort_rd: latency=%0d prdata=%h, expected 4 5555aaaa", lat, rd);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int lat, t0;
        @(posedge pclk); #1;
        psel = '0; psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h10; pwdata = 32'h0; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        #2 presetn = 1'b0;
        #1;
        checks++;
        if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0 || prdata[0] !== 32'h0) begin
            failures++;
            $display("FAIL rst_wait: pready=%b pslverr=%b prdata=%h, expected 0 0 00000000",
                     pready[0], pslverr[0], prdata[0]);
        end
        repeat (2) @(posedge pclk);
        #1;
        psel = '0; penable = 1'b0; presetn = 1'b1;
        xfer(0, 1'b0, 'h10, 32'h0, 4'h0, rd, err, lat, t0);
        checks++;
        if (lat !== 3 || rd !== model_rd(0, 'h10)) begin
            failures++;
            $display("FAIL rst_wait_after: latency=%0d prdata=%h, expected 3 %h", lat, rd, model_rd(0, 'h10));
        end
        // Reset landing inside the READY cycle of a read, then of a write.
        presetn = 1'b0;
        #1;
        checks++;
        if (pready[0] !== 1'b0 || prdata[0] !== 32'h0) begin
            failures++;
            $display("FAIL rst_ready_async: pready=%b prdata=%h, expected 0 00000000", pready[0], prdata[0]);
        end
        idle(1);
        presetn = 1'b1;
        xfer(0, 1'b1, 'h10, 32'h0, 4'hF, rd, err, lat, t0);
        presetn = 1'b0;
        idle(2);
        presetn = 1'b1;
        xfer(0, 1'b0, 'h10, 32'h0, 4'h0, rd, err, lat, t0);
        checks++;
        if (lat !== 3 || rd !== model_rd(0, 'h10)) begin
            failures++;
            $display("FAIL rst_ready_nowrite: latency=%0d prdata=%h, expected 3 %h", lat, rd, model_rd(0, 'h10));
        end
        idle(1);
    endtask

    task automatic test_random();
        logic [31:0] rd, d, exp_rd; logic err; int lat, t0, k, a; bit wr; logic [3:0] s;
        for (int kk = 0; kk < N; kk++) begin
            for (int aa = 0; aa < MW && aa < DP[kk]; aa++) begin
                d = $urandom;
                xfer(kk, 1'b1, aa, d, 4'hF, rd, err, lat, t0);
                model_wr(kk, aa, d, 4'hF);
            end
        end
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            k  = $urandom_range(0, N - 1);
            wr = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, MW - 1);
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            exp_rd = model_rd(k, a);
            xfer(k, wr, a, d, s, rd, err, lat, t0);
            if (wr) model_wr(k, a, d, s);
            checks++;
            if (lat !== WC[k] + 1 || err !== (a >= DP[k])) begin
                failures++;
                $display("FAIL rand_resp[%0d] slave=%0d addr=%0d: latency=%0d slverr=%b, expected %0d %b",
                         i, k, a, lat, err, WC[k] + 1, (a >= DP[k]));
            end
            if (!wr) begin
                checks++;
                if (rd !== exp_rd) begin
                    failures++;
                    $display("FAIL rand_rdata[%0d] slave=%0d addr=%0d: prdata=%h, expected %h",
                             i, k, a, rd, exp_rd);
                end
            end
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_back_to_back();
        test_error();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
